// File: rtl/dsp_mac_mc_if.sv
// Sample and result bundle for dsp_mac_mc.
// The source drives the sample side; the MAC drives the result side.
interface dsp_mac_mc_if #(
   parameter int AW = 9,
   parameter int BW = 8,
   parameter int PW = 24,
   parameter int TW = 1,
   parameter int OW = 8,
   parameter int CW = 2
);
   logic                 ivalid;
   logic                 load;
   logic [CW-1:0]        ch;
   logic [TW-1:0]        itag;
   logic signed [AW-1:0] A;
   logic signed [AW-1:0] D;
   logic signed [BW-1:0] B;
   logic signed [PW-1:0] C;

   logic                 ovalid;
   logic [CW-1:0]        och;
   logic [TW-1:0]        otag;
   logic signed [PW-1:0] P;
   logic signed [OW-1:0] Q;
   logic                 osat;
   logic                 oovf;

   modport master (
      output ivalid, load, ch, itag, A, D, B, C,
      input  ovalid, och, otag, P, Q, osat, oovf
   );

   modport slave (
      input  ivalid, load, ch, itag, A, D, B, C,
      output ovalid, och, otag, P, Q, osat, oovf
   );
endinterface

// File: rtl/dsp_mac_mc.sv
// Multi-channel pre-subtract MAC: acc[ch] = (load ? C : acc[ch]) + (A-D)*B.
// Five register stages; the result also comes out rounded, shifted and saturated as Q.
module dsp_mac_mc #(
   parameter int AW  = 9,
   parameter int BW  = 8,
   parameter int PW  = 24,
   parameter int NCH = 3,
   parameter int TW  = 1,
   parameter int SH  = 8,
   parameter int OW  = 8
) (
   input  logic        clk,
   input  logic        rst,
   dsp_mac_mc_if.slave bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int MW = AW + 1 + BW;
   localparam logic [CW:0]          NCH_W = (CW+1)'(NCH);
   localparam logic signed [PW:0]   QMAX  = (PW+1)'((1 << (OW-1)) - 1);
   localparam logic signed [PW:0]   QMIN  = (PW+1)'(-(1 << (OW-1)));

   if (PW < MW) begin : g_chk_pw
      $error("dsp_mac_mc: PW must be at least AW+1+BW");
   end
   if (NCH < 1) begin : g_chk_nch
      $error("dsp_mac_mc: NCH must be at least 1");
   end
   if (OW > PW - SH) begin : g_chk_ow
      $error("dsp_mac_mc: OW must not exceed PW-SH");
   end

   logic                  r_v1, r_load1;
   logic [CW-1:0]         r_ch1;
   logic [TW-1:0]         r_tag1;
   logic signed [AW-1:0]  r_a1, r_d1;
   logic signed [BW-1:0]  r_b1;
   logic signed [PW-1:0]  r_c1;

   logic                  r_v2, r_load2;
   logic [CW-1:0]         r_ch2;
   logic [TW-1:0]         r_tag2;
   logic signed [AW:0]    r_ad2;
   logic signed [BW-1:0]  r_b2;
   logic signed [PW-1:0]  r_c2;

   logic                  r_v3, r_load3;
   logic [CW-1:0]         r_ch3;
   logic [TW-1:0]         r_tag3;
   logic signed [MW-1:0]  r_m3;
   logic signed [PW-1:0]  r_c3;

   logic signed [PW-1:0]  r_acc [NCH];
   logic                  r_v4;
   logic [CW-1:0]         r_ch4;
   logic [TW-1:0]         r_tag4;
   logic signed [PW-1:0]  r_p4;
   logic                  r_ovf4;

   logic                  r_ovalid;
   logic [CW-1:0]         r_och;
   logic [TW-1:0]         r_otag;
   logic signed [PW-1:0]  r_p5;
   logic signed [OW-1:0]  r_q5;
   logic                  r_osat5;
   logic                  r_oovf5;

   logic signed [AW:0]    w_ad;
   logic signed [MW-1:0]  w_m;
   logic signed [PW-1:0]  w_m_ext;
   logic                  w_hit3;
   logic signed [PW-1:0]  w_acc_rd;
   logic signed [PW-1:0]  w_addend;
   logic signed [PW-1:0]  w_sum;
   logic                  w_ovf;
   logic signed [PW:0]    w_r;
   logic signed [OW-1:0]  w_q;
   logic                  w_sat;

   assign w_ad    = (AW+1)'(r_a1) - (AW+1)'(r_d1);
   assign w_m     = MW'(r_ad2) * MW'(r_b2);
   assign w_m_ext = PW'(r_m3);
   assign w_hit3  = r_v3 && ({1'b0, r_ch3} < NCH_W);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0; r_load1 <= 1'b0; r_ch1 <= '0; r_tag1 <= '0;
         r_a1 <= '0;   r_d1 <= '0;      r_b1 <= '0;  r_c1 <= '0;
         r_v2 <= 1'b0; r_load2 <= 1'b0; r_ch2 <= '0; r_tag2 <= '0;
         r_ad2 <= '0;  r_b2 <= '0;      r_c2 <= '0;
         r_v3 <= 1'b0; r_load3 <= 1'b0; r_ch3 <= '0; r_tag3 <= '0;
         r_m3 <= '0;   r_c3 <= '0;
      end else begin
         r_v1 <= bus.ivalid; r_load1 <= bus.load; r_ch1 <= bus.ch; r_tag1 <= bus.itag;
         r_a1 <= bus.A;      r_d1 <= bus.D;       r_b1 <= bus.B;   r_c1 <= bus.C;
         r_v2 <= r_v1;       r_load2 <= r_load1;  r_ch2 <= r_ch1;  r_tag2 <= r_tag1;
         r_ad2 <= w_ad;      r_b2 <= r_b1;        r_c2 <= r_c1;
         r_v3 <= r_v2;       r_load3 <= r_load2;  r_ch3 <= r_ch2;  r_tag3 <= r_tag2;
         r_m3 <= w_m;        r_c3 <= r_c2;
      end
   end

   // Read side of the single-cycle read-modify-write, so back-to-back hits on one channel need no forwarding.
   always_comb begin
      w_acc_rd = '0;
      for (int i = 0; i < NCH; i++) begin
         if (r_ch3 == CW'(i)) w_acc_rd = r_acc[i];
      end
   end

   assign w_addend = r_load3 ? r_c3 : w_acc_rd;
   assign w_sum    = w_addend + w_m_ext;
   assign w_ovf    = (w_addend[PW-1] == w_m_ext[PW-1]) && (w_sum[PW-1] != w_addend[PW-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
         r_v4   <= 1'b0;
         r_ch4  <= '0;
         r_tag4 <= '0;
         r_p4   <= '0;
         r_ovf4 <= 1'b0;
      end else begin
         r_v4 <= w_hit3;
         for (int i = 0; i < NCH; i++) begin
            if (w_hit3 && r_ch3 == CW'(i)) r_acc[i] <= w_sum;
         end
         if (w_hit3) begin
            r_ch4  <= r_ch3;
            r_tag4 <= r_tag3;
            r_p4   <= w_sum;
            r_ovf4 <= w_ovf;
         end
      end
   end

   // Rounding add is done one bit wider than P so it can never wrap.
   if (SH > 0) begin : g_round
      assign w_r = ((PW+1)'(r_p4) + (PW+1)'(1 << (SH-1))) >>> SH;
   end else begin : g_noround
      assign w_r = (PW+1)'(r_p4);
   end

   always_comb begin
      w_q   = w_r[OW-1:0];
      w_sat = 1'b0;
      if (w_r > QMAX) begin
         w_q   = QMAX[OW-1:0];
         w_sat = 1'b1;
      end else if (w_r < QMIN) begin
         w_q   = QMIN[OW-1:0];
         w_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovalid <= 1'b0;
         r_och    <= '0;
         r_otag   <= '0;
         r_p5     <= '0;
         r_q5     <= '0;
         r_osat5  <= 1'b0;
         r_oovf5  <= 1'b0;
      end else begin
         r_ovalid <= r_v4;
         if (r_v4) begin
            r_och   <= r_ch4;
            r_otag  <= r_tag4;
            r_p5    <= r_p4;
            r_q5    <= w_q;
            r_osat5 <= w_sat;
            r_oovf5 <= r_ovf4;
         end
      end
   end

   assign bus.ovalid = r_ovalid;
   assign bus.och    = r_och;
   assign bus.otag   = r_otag;
   assign bus.P      = r_p5;
   assign bus.Q      = r_q5;
   assign bus.osat   = r_osat5;
   assign bus.oovf   = r_oovf5;
endmodule

// File: tb/tb_dsp_mac_mc.sv
// Bench for dsp_mac_mc: directed cases pinned to literals plus randomized traffic,
// all scored against an arithmetic per-channel accumulator model.
module tb_dsp_mac_mc;
   localparam int AW = 9, BW = 8, PW = 24, NCH = 3, TW = 1, SH = 8, OW = 8, CW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   typedef struct {
      int     due;
      longint p;
      longint q;
      bit     osat;
      bit     oovf;
      int     ch;
      int     tag;
   } exp_t;

   typedef struct {
      int     at;
      longint p;
      longint q;
      bit     osat;
      bit     oovf;
      int     ch;
      int     tag;
   } obs_t;

   exp_t   exp_q[$];
   obs_t   seen[$];
   longint acc_m[NCH];
   exp_t   e_cur;
   obs_t   o_cur;
   bit     ev;

   dsp_mac_mc_if #(.AW(AW), .BW(BW), .PW(PW), .TW(TW), .OW(OW), .CW(CW)) bus();

   dsp_mac_mc #(.AW(AW), .BW(BW), .PW(PW), .NCH(NCH), .TW(TW), .SH(SH), .OW(OW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic signed [63:0] got, logic signed [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic longint wrap_pw(longint x);
      longint md;
      longint y;
      md = longint'(1) <<< PW;
      y  = x & (md - 1);
      if (y >= md / 2) y = y - md;
      return y;
   endfunction

   // Model: exact product, exact sum, then reduce modulo 2^PW; overflow is "the exact sum did not fit".
   task automatic model(bit ld, int ch, int tag, int a, int d, int b, longint c);
      longint m, full, w, r, qmax, qmin;
      exp_t   e;
      if (ch >= NCH) return;
      qmax = (longint'(1) <<< (OW-1)) - 1;
      qmin = -(longint'(1) <<< (OW-1));
      m    = (longint'(a) - longint'(d)) * longint'(b);
      full = (ld ? c : acc_m[ch]) + m;
      w    = wrap_pw(full);
      acc_m[ch] = w;
      r = (SH > 0) ? ((w + (longint'(1) <<< (SH-1))) >>> SH) : w;
      e.due  = cyc + 5;
      e.p    = w;
      e.oovf = (full != w);
      e.osat = (r > qmax) || (r < qmin);
      e.q    = (r > qmax) ? qmax : ((r < qmin) ? qmin : r);
      e.ch   = ch;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   task automatic drive(bit v, bit ld, int ch, int tag, int a, int d, int b, longint c);
      @(negedge clk);
      #1;
      bus.ivalid = v;
      bus.load   = ld;
      bus.ch     = CW'(ch);
      bus.itag   = TW'(tag);
      bus.A      = AW'(a);
      bus.D      = AW'(d);
      bus.B      = BW'(b);
      bus.C      = PW'(c);
      if (v) model(ld, ch, tag, a, d, b, c);
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         check("rst_outputs", {26'd0, bus.ovalid, bus.osat, bus.oovf, bus.och, bus.otag, bus.Q, bus.P}, 64'sd0);
      end else begin
         ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         check("ovalid", {63'd0, bus.ovalid}, {63'd0, ev});
         if (bus.ovalid === 1'b1) begin
            o_cur.at   = cyc;
            o_cur.p    = bus.P;
            o_cur.q    = bus.Q;
            o_cur.osat = bus.osat;
            o_cur.oovf = bus.oovf;
            o_cur.ch   = int'(bus.och);
            o_cur.tag  = int'(bus.otag);
            seen.push_back(o_cur);
         end
         if (ev) begin
            e_cur = exp_q.pop_front();
            check("P",    bus.P, e_cur.p);
            check("Q",    bus.Q, e_cur.q);
            check("osat", {63'd0, bus.osat}, {63'd0, e_cur.osat});
            check("oovf", {63'd0, bus.oovf}, {63'd0, e_cur.oovf});
            check("och",  {62'd0, bus.och}, e_cur.ch);
            check("otag", {63'd0, bus.otag}, e_cur.tag);
         end
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            miscompares++;
            $display("FAIL missed_result: expected result due at cycle %0d never appeared", exp_q[0].due);
            void'(exp_q.pop_front());
         end
      end
   end

   int t0;
   int t3_ch[7]  = '{0, 1, 2, 0, 0, 1, 2};
   int t3_c[7]   = '{0, 10, 20, 0, 0, 0, 0};
   int t3_ld[7]  = '{1, 1, 1, 1, 0, 0, 0};
   int t3_p[7]   = '{1, 11, 21, 1, 2, 12, 22};

   initial begin
      for (int i = 0; i < NCH; i++) acc_m[i] = 0;
      bus.ivalid = 1'b0; bus.load = 1'b0; bus.ch = '0; bus.itag = '0;
      bus.A = '0; bus.D = '0; bus.B = '0; bus.C = '0;
      idle(3);
      rst = 1'b0;

      // basic MAC on ch0 with latency pin
      seen.delete();
      drive(1, 1, 0, 0, 100, -50, 10, 0);
      t0 = cyc;
      drive(1, 0, 0, 1, 100, -50, 10, 0);
      drive(1, 0, 0, 0, 100, -50, 10, 0);
      idle(7);
      check("t1_count", seen.size(), 3);
      if (seen.size() == 3) begin
         check("t1_latency", seen[0].at - t0, 5);
         check("t1_p0", seen[0].p, 1500);
         check("t1_p1", seen[1].p, 3000);
         check("t1_p2", seen[2].p, 4500);
         check("t1_q2", seen[2].q, 18);
         check("t1_osat2", {63'd0, seen[2].osat}, 0);
         check("t1_tag1", seen[1].tag, 1);
      end

      // saturation both ways
      seen.delete();
      drive(1, 1, 0, 0, 255, -256, 127, 0);
      drive(1, 1, 0, 0, -256, 255, 127, 0);
      idle(7);
      check("t2_count", seen.size(), 2);
      if (seen.size() == 2) begin
         check("t2_p_pos", seen[0].p, 64897);
         check("t2_q_pos", seen[0].q, 127);
         check("t2_sat_pos", {63'd0, seen[0].osat}, 1);
         check("t2_p_neg", seen[1].p, -64897);
         check("t2_q_neg", seen[1].q, -128);
         check("t2_sat_neg", {63'd0, seen[1].osat}, 1);
      end

      // channel interleave, M=1
      seen.delete();
      for (int i = 0; i < 7; i++) drive(1, t3_ld[i][0], t3_ch[i], i % 2, 1, 0, 1, t3_c[i]);
      idle(7);
      check("t3_count", seen.size(), 7);
      if (seen.size() == 7) begin
         for (int i = 0; i < 7; i++) begin
            check("t3_p", seen[i].p, t3_p[i]);
            check("t3_ch", seen[i].ch, t3_ch[i]);
            check("t3_tag", seen[i].tag, i % 2);
         end
      end

      // gaps and a dropped out-of-range channel
      seen.delete();
      drive(1, 1, 0, 0, 1, 0, 1, 5);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 1, 1, 0, 1, 7);
      drive(1, 1, 3, 0, 1, 0, 1, 100);
      idle(7);
      check("t5_count", seen.size(), 2);
      if (seen.size() == 2) check("t5_spacing", seen[1].at - seen[0].at, 2);
      seen.delete();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 2, 0, 0, 0, 0, 0);
      idle(7);
      check("t5_probe_count", seen.size(), 3);
      if (seen.size() == 3) begin
         check("t5_acc0", seen[0].p, 6);
         check("t5_acc1", seen[1].p, 8);
         check("t5_acc2", seen[2].p, 22);
      end

      // wrap in both directions
      seen.delete();
      drive(1, 1, 0, 0, 1, 0, 1, 64'sh7FFFFF);
      drive(1, 0, 0, 0, 0, 1, 1, 0);
      idle(7);
      check("t4_count", seen.size(), 2);
      if (seen.size() == 2) begin
         check("t4_p_up", seen[0].p, -8388608);
         check("t4_ovf_up", {63'd0, seen[0].oovf}, 1);
         check("t4_q_up", seen[0].q, -128);
         check("t4_sat_up", {63'd0, seen[0].osat}, 1);
         check("t4_p_dn", seen[1].p, 8388607);
         check("t4_ovf_dn", {63'd0, seen[1].oovf}, 1);
      end

      // reset with four samples in flight
      seen.delete();
      for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 3, 0, 2, 50);
      @(negedge clk);
      #1;
      rst = 1'b1;
      bus.ivalid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NCH; i++) acc_m[i] = 0;
      idle(3);
      rst = 1'b0;
      check("t6_no_ovalid", seen.size(), 0);
      drive(1, 0, 1, 1, 7, 0, 1, 0);
      idle(7);
      check("t6_count", seen.size(), 1);
      if (seen.size() == 1) check("t6_p", seen[0].p, 7);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(3) != 0,
               $urandom_range(3) == 0,
               ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2)),
               int'($urandom_range(1)),
               int'($urandom_range(511)) - 256,
               int'($urandom_range(511)) - 256,
               int'($urandom_range(255)) - 128,
               longint'($urandom_range(24'hFFFFFF)) - 8388608);
      end
      idle(8);
      check("drain_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
